// File: rtl/full_adder_pkg.sv
// Shared constants and the packed result layout for the registered ripple-carry adder.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // Result vector holds {ovf, cout, sum}, i.e. two flag bits above the sum.
  function automatic int fa_result_w(input int width);
    return width + 2;
  endfunction

  typedef struct packed {
    logic                    ovf;
    logic                    cout;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full-adder cell: the leaf of the ripple-carry chain.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed overflow and a valid flag.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int RW = fa_result_w(WIDTH);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  logic             ovf_comb;
  logic [RW-1:0]    result_d, result_q;
  logic             valid_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .ci_i (carry[i]),
      .s_o  (sum_comb[i]),
      .co_o (carry[i+1])
    );
  end

  // For WIDTH=1, carry[0] (= cin) is the carry into the MSB.
  assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

  // Idle cycles select the held value, so X on a/b/cin never reaches the registers.
  assign result_d = in_valid ? {ovf_comb, carry[WIDTH], sum_comb} : result_q;

  // NOTE: data registers are reset too, because outputs must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= in_valid;
    end
  end

  assign {ovf, cout, sum} = result_q;
  assign out_valid        = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench: WIDTH=1, 8 and 16 adders run in lockstep against an arithmetic model.
module tb_full_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [0:0]  a1, b1, sum1;
  logic [7:0]  a8, b8, sum8;
  logic [15:0] a16, b16, sum16;
  logic        c1, c8, c16;
  logic        ov1, ov8, ov16;
  logic        co1, co8, co16;
  logic        of1, of8, of16;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(sum1), .cout(co1), .ovf(of1));
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(sum8), .cout(co8), .ovf(of8));
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16), .cin(c16),
    .out_valid(ov16), .sum(sum16), .cout(co16), .ovf(of16));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [17:0] r1, r8, r16;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned total of a+b+cin; overflow when both operands share a sign the sum lacks.
  function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic cv);
    logic [63:0] mask, ta, tb, tot;
    logic [15:0] s;
    logic        co, of;
    mask = (64'd1 << w) - 64'd1;
    ta   = 64'(av) & mask;
    tb   = 64'(bv) & mask;
    tot  = ta + tb + 64'(cv);
    s    = 16'(tot & mask);
    co   = tot[w];
    of   = (ta[w-1] == tb[w-1]) && (s[w-1] != ta[w-1]);
    return {of, co, s};
  endfunction

  // Monitor: checks every DUT every cycle against the scoreboard and the last held result.
  logic [17:0] held1 = '0, held8 = '0, held16 = '0;
  logic        exp_v;
  exp_t        e;

  always @(negedge clk) begin
    exp_v = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      held1  = '0;
      held8  = '0;
      held16 = '0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e      = exp_q.pop_front();
      exp_v  = 1'b1;
      held1  = e.r1;
      held8  = e.r8;
      held16 = e.r16;
    end
    check("valid_w1",  32'(ov1),  32'(exp_v));
    check("valid_w8",  32'(ov8),  32'(exp_v));
    check("valid_w16", 32'(ov16), 32'(exp_v));
    check("result_w1",  32'({of1, co1, 16'(sum1)}), 32'(held1));
    check("result_w8",  32'({of8, co8, 16'(sum8)}), 32'(held8));
    check("result_w16", 32'({of16, co16, sum16}),   32'(held16));
  end

  task automatic rand_inputs();
    a1  = 1'($urandom);  b1  = 1'($urandom);  c1  = 1'($urandom);
    a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
  endtask

  // Drive one cycle; a valid vector is scoreboarded only if reset is released when it is sampled.
  task automatic issue(input logic v);
    exp_t x;
    in_valid = v;
    if (v && rst_n) begin
      x.due = cyc + 1;
      x.r1  = model(1,  16'(a1), 16'(b1), c1);
      x.r8  = model(8,  16'(a8), 16'(b8), c8);
      x.r16 = model(16, a16,     b16,     c16);
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous assertion between edges; outputs must clear before the next edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'({ov1, ov8, ov16}), 32'(0));
    check("async_w8",    32'({of8, co8, sum8}), 32'(0));
    check("async_w16",   32'({of16, co16, sum16}), 32'(0));
    @(posedge clk);
    #1;
    rand_inputs();
    issue(1'b1);
    rst_n = 1'b1;
  endtask

  logic [7:0] da[4] = '{8'hFF, 8'h7F, 8'h80, 8'hFF};
  logic [7:0] db[4] = '{8'h00, 8'h01, 8'h80, 8'hFF};
  logic       dc[4] = '{1'b1,  1'b0,  1'b0,  1'b1};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    rand_inputs();
    #2;
    check("reset_noclk", 32'({ov1, ov8, ov16, of8, co8, sum8}), 32'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      issue(1'b1);
    end
    rst_n = 1'b1;

    // WIDTH=1 exhaustive over (a,b,cin)
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      rand_inputs();
      {a1, b1, c1} = abc;
      issue(1'b1);
    end

    // WIDTH=8 ripple and corner vectors
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      a8 = da[i];
      b8 = db[i];
      c8 = dc[i];
      issue(1'b1);
    end

    // Hold: one valid result of 8'h3C, then idle with random and unknown inputs
    rand_inputs();
    a8 = 8'h3C; b8 = 8'h00; c8 = 1'b0;
    issue(1'b1);
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      issue(1'b0);
    end
    a1 = 'x; b1 = 'x; c1 = 'x; a8 = 'x; b8 = 'x; c8 = 'x; a16 = 'x; b16 = 'x; c16 = 'x;
    issue(1'b0);
    issue(1'b0);

    // Streaming with one reset pulse mid-stream
    for (int k = 0; k < 100; k++) begin
      if (k == 50) mid_reset();
      rand_inputs();
      issue(1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      issue(1'b0);
    end
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
